// File: rtl/imem_loader_pkg.sv
// Shared definitions for the byte-serial instruction-memory loader.
// Holds the loader FSM state encodings, the default instruction-memory
// address width, and a helper that decodes which states accept input bytes.
package imem_loader_pkg;

    localparam int unsigned DefaultAddrWidth = 10;

    // Loader FSM states. The four byte-accepting states sit at 0..3.
    localparam logic [2:0] StHdr0  = 3'd0;
    localparam logic [2:0] StHdr1  = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StCsum  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;
    localparam logic [2:0] StError = 3'd5;

    // True in every state that consumes bytes from the input stream.
    function automatic logic accepts_bytes(input logic [2:0] st);
        return (st == StHdr0) || (st == StHdr1) || (st == StData) || (st == StCsum);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word assembler for the program loader.
// Ports:
//   clk, reset   system clock and synchronous active-high reset
//   byte_valid   a payload byte is consumed this cycle
//   byte_in      the payload byte
//   word_ready   combinational strobe: this byte completes a 32-bit word
//   word         the assembled word; valid while word_ready is high
// The first three bytes of a word are held in a 24-bit shift register; the
// fourth byte is taken live from byte_in so the word is available on the same
// edge that accepts it.
module imem_loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    assign word       = {shift_q, byte_in};
    assign word_ready = byte_valid && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= 24'd0;
            cnt_q   <= 2'd0;
        end else if (byte_valid) begin
            shift_q <= {shift_q[15:0], byte_in};
            cnt_q   <= cnt_q + 2'd1;  // wraps 3 -> 0 at each word boundary
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-serial program loader feeding the MIPS core's instruction memory.
// Receives a frame {N[15:8], N[7:0], 4*N payload bytes, XOR checksum} over a
// valid/ready byte stream, writes big-endian words to consecutive word
// addresses, and holds the core in reset until a complete, valid image is in.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   in_valid      input byte present
//   in_ready      loader accepts a byte this cycle
//   in_data       input byte
//   im_we         instruction-memory write enable, one-cycle pulse
//   im_addr       word address of the write
//   im_wdata      word to write
//   cpu_reset     reset to the core; low only once the image is verified
//   load_done     image loaded and checksum matched (sticky)
//   load_error    framing or checksum failure (sticky)
//   words_loaded  words committed to memory so far
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [16:0] Capacity = 17'd1 << ADDR_WIDTH;

    logic [2:0]            state_q, state_d;
    logic [7:0]            n_hi_q;
    logic [15:0]           n_q;
    logic [7:0]            csum_q;
    logic [ADDR_WIDTH:0]   words_q;
    logic                  im_we_q;
    logic [ADDR_WIDTH-1:0] im_addr_q;
    logic [31:0]           im_wdata_q;

    logic        accept;
    logic        data_byte;
    logic        word_ready;
    logic [31:0] word;
    logic [16:0] n_in;
    logic        last_word;

    assign accept    = in_valid && in_ready;
    assign data_byte = accept && (state_q == StData);
    assign n_in      = {1'b0, n_hi_q, in_data};

    // words_q has already counted every earlier word by the time the next
    // word completes (at least four edges later), so it is this word's index.
    assign last_word = ({1'b0, n_q} == (17'(words_q) + 17'd1));

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (data_byte),
        .byte_in    (in_data),
        .word_ready (word_ready),
        .word       (word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHdr0: if (accept) state_d = StHdr1;
            StHdr1: begin
                if (accept) begin
                    if (n_in > Capacity)   state_d = StError;
                    else if (n_in == 17'd0) state_d = StCsum;
                    else                    state_d = StData;
                end
            end
            StData: if (word_ready && last_word) state_d = StCsum;
            StCsum: begin
                if (accept) state_d = (in_data == csum_q) ? StDone : StError;
            end
            default: state_d = state_q;  // Done / Error are terminal
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StHdr0;
            n_hi_q     <= 8'd0;
            n_q        <= 16'd0;
            csum_q     <= 8'd0;
            words_q    <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept && (state_q == StHdr0)) n_hi_q <= in_data;
            if (accept && (state_q == StHdr1)) n_q <= {n_hi_q, in_data};
            if (data_byte) csum_q <= csum_q ^ in_data;
            im_we_q <= word_ready;
            if (word_ready) begin
                im_addr_q  <= words_q[ADDR_WIDTH-1:0];
                im_wdata_q <= word;
            end
            // Count a word when memory commits it, one edge after it is queued.
            if (im_we_q) words_q <= words_q + 1'b1;
        end
    end

    assign in_ready     = accepts_bytes(state_q);
    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign load_done    = (state_q == StDone);
    assign load_error   = (state_q == StError);
    assign cpu_reset    = (state_q != StDone);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic        a_ready, a_we, a_cpu_reset, a_done, a_error;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic [10:0] a_words;

    logic        b_ready, b_we, b_cpu_reset, b_done, b_error;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;
    logic [4:0]  b_words;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(10)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ready), .in_data(in_data),
        .im_we(a_we), .im_addr(a_addr), .im_wdata(a_wdata), .cpu_reset(a_cpu_reset),
        .load_done(a_done), .load_error(a_error), .words_loaded(a_words)
    );

    imem_loader #(.ADDR_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_ready), .in_data(in_data),
        .im_we(b_we), .im_addr(b_addr), .im_wdata(b_wdata), .cpu_reset(b_cpu_reset),
        .load_done(b_done), .load_error(b_error), .words_loaded(b_words)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write logs, sampled mid-cycle; also enforce no back-to-back write pulses.
    logic [31:0] a_log_addr[$], a_log_data[$], b_log_addr[$], b_log_data[$];
    logic a_we_prev = 1'b0, b_we_prev = 1'b0;

    always @(negedge clk) begin
        if (a_we) begin
            a_log_addr.push_back(32'(a_addr));
            a_log_data.push_back(a_wdata);
            check("a_we_not_consecutive", 32'(a_we_prev), 32'd0);
        end
        if (b_we) begin
            b_log_addr.push_back(32'(b_addr));
            b_log_data.push_back(b_wdata);
            check("b_we_not_consecutive", 32'(b_we_prev), 32'd0);
        end
        a_we_prev = a_we;
        b_we_prev = b_we;
    end

    task automatic clear_logs();
        a_log_addr.delete(); a_log_data.delete();
        b_log_addr.delete(); b_log_data.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_byte_gappy(input logic [7:0] b);
        for (int g = 0; g < 6; g++) begin
            if ($urandom_range(1, 0) == 0) break;
            in_valid = 1'b0;
            in_data = 8'hxx;
            @(posedge clk); #1;
        end
        send_byte(b);
    endtask

    // Two-word frame; the XOR of its payload bytes is 0x34.
    logic [7:0] frame[11];

    task automatic check_two_word_log(input string tag);
        check({tag, "_nwrites"}, 32'(a_log_addr.size()), 32'd2);
        if (a_log_addr.size() >= 2) begin
            check({tag, "_addr0"}, a_log_addr[0], 32'd0);
            check({tag, "_data0"}, a_log_data[0], 32'h34080005);
            check({tag, "_addr1"}, a_log_addr[1], 32'd1);
            check({tag, "_data1"}, a_log_data[1], 32'h0000000D);
        end
    endtask

    typedef struct {
        logic [7:0]  b;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        ready;
        logic        cpu_reset;
        logic        done;
        logic        error;
        logic [10:0] words;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [7:0] cs;
        logic [31:0] w;

        frame = '{8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h05,
                  8'h00, 8'h00, 8'h00, 8'h0D, 8'h34};
        // Expected outputs just after the edge that accepts each byte.
        tbl[0]  = '{8'h00, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 11'd0};
        tbl[1]  = '{8'h02, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 11'd0};
        tbl[2]  = '{8'h34, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 11'd0};
        tbl[3]  = '{8'h08, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 11'd0};
        tbl[4]  = '{8'h00, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 11'd0};
        tbl[5]  = '{8'h05, 1'b1, 10'd0, 32'h34080005, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0};
        tbl[6]  = '{8'h00, 1'b0, 10'd0, 32'h34080005, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1};
        tbl[7]  = '{8'h00, 1'b0, 10'd0, 32'h34080005, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1};
        tbl[8]  = '{8'h00, 1'b0, 10'd0, 32'h34080005, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1};
        tbl[9]  = '{8'h0D, 1'b1, 10'd1, 32'h0000000D, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1};
        tbl[10] = '{8'h34, 1'b0, 10'd1, 32'h0000000D, 1'b0, 1'b0, 1'b1, 1'b0, 11'd2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        check("rst_in_ready", 32'(a_ready), 32'd1);
        check("rst_cpu_reset", 32'(a_cpu_reset), 32'd1);
        check("rst_we", 32'(a_we), 32'd0);
        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_wdata", a_wdata, 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_error", 32'(a_error), 32'd0);
        check("rst_words", 32'(a_words), 32'd0);

        // Full-rate two-word frame, cycle by cycle
        for (int i = 0; i < 11; i++) begin
            send_byte(tbl[i].b);
            check($sformatf("v%0d_we", i), 32'(a_we), 32'(tbl[i].we));
            check($sformatf("v%0d_addr", i), 32'(a_addr), 32'(tbl[i].addr));
            check($sformatf("v%0d_wdata", i), a_wdata, tbl[i].wdata);
            check($sformatf("v%0d_ready", i), 32'(a_ready), 32'(tbl[i].ready));
            check($sformatf("v%0d_cpu_reset", i), 32'(a_cpu_reset), 32'(tbl[i].cpu_reset));
            check($sformatf("v%0d_done", i), 32'(a_done), 32'(tbl[i].done));
            check($sformatf("v%0d_error", i), 32'(a_error), 32'(tbl[i].error));
            check($sformatf("v%0d_words", i), 32'(a_words), 32'(tbl[i].words));
        end
        @(posedge clk); #1;
        check_two_word_log("full");
        // A byte offered after Done is not consumed
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("done_sticky", 32'(a_done), 32'd1);
        check("done_ready", 32'(a_ready), 32'd0);
        check("done_words", 32'(a_words), 32'd2);

        // Bad checksum: both words still written, then Error
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(frame[i]);
        send_byte(8'h3B);
        @(posedge clk); #1;
        check("badcs_error", 32'(a_error), 32'd1);
        check("badcs_done", 32'(a_done), 32'd0);
        check("badcs_cpu_reset", 32'(a_cpu_reset), 32'd1);
        check("badcs_ready", 32'(a_ready), 32'd0);
        check("badcs_words", 32'(a_words), 32'd2);
        check_two_word_log("badcs");

        // Empty image
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(posedge clk); #1;
        check("n0_done", 32'(a_done), 32'd1);
        check("n0_cpu_reset", 32'(a_cpu_reset), 32'd0);
        check("n0_words", 32'(a_words), 32'd0);
        check("n0_nwrites", 32'(a_log_addr.size()), 32'd0);
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("n0bad_error", 32'(a_error), 32'd1);
        check("n0bad_cpu_reset", 32'(a_cpu_reset), 32'd1);

        // Capacity limit on the 16-word instance
        do_reset();
        send_byte(8'h00); send_byte(8'h11);
        check("n17_error", 32'(b_error), 32'd1);
        check("n17_ready", 32'(b_ready), 32'd0);
        check("n17_cpu_reset", 32'(b_cpu_reset), 32'd1);
        do_reset();
        send_byte(8'h00); send_byte(8'h10);
        cs = 8'h00;
        for (int i = 0; i < 16; i++) begin
            w = 32'h11223300 | 32'(i);
            for (int j = 3; j >= 0; j--) begin
                send_byte(w[8*j +: 8]);
                cs = cs ^ w[8*j +: 8];
            end
        end
        send_byte(cs);
        @(posedge clk); #1;
        check("n16_done", 32'(b_done), 32'd1);
        check("n16_cpu_reset", 32'(b_cpu_reset), 32'd0);
        check("n16_words", 32'(b_words), 32'd16);
        check("n16_nwrites", 32'(b_log_addr.size()), 32'd16);
        if (b_log_addr.size() == 16) begin
            check("n16_last_addr", b_log_addr[15], 32'd15);
            check("n16_last_data", b_log_data[15], 32'h1122330F);
            check("n16_first_data", b_log_data[0], 32'h11223300);
        end

        // Random input gaps
        do_reset();
        for (int i = 0; i < 11; i++) send_byte_gappy(frame[i]);
        @(posedge clk); #1;
        check("gap_done", 32'(a_done), 32'd1);
        check("gap_error", 32'(a_error), 32'd0);
        check("gap_words", 32'(a_words), 32'd2);
        check_two_word_log("gap");

        // Reset in mid-load, then a fresh frame
        do_reset();
        for (int i = 0; i < 7; i++) send_byte(frame[i]);
        check("mid_words_before", 32'(a_words), 32'd1);
        do_reset();
        check("mid_cpu_reset", 32'(a_cpu_reset), 32'd1);
        check("mid_ready", 32'(a_ready), 32'd1);
        check("mid_words", 32'(a_words), 32'd0);
        for (int i = 0; i < 6; i++) send_byte(frame[i]);
        check("reload_cpu_reset", 32'(a_cpu_reset), 32'd1);
        for (int i = 6; i < 11; i++) send_byte(frame[i]);
        @(posedge clk); #1;
        check("reload_done", 32'(a_done), 32'd1);
        check("reload_words", 32'(a_words), 32'd2);
        check_two_word_log("reload");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
